// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its neighbours: branch resolution in,
// instruction-memory request/grant/response, and the downstream instruction port.
`timescale 1ns/1ps
interface pc_sequencer_if;
    logic        BranchValid;
    logic        BranchTaken;
    logic [31:0] BranchTarget;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        misalign_err;

    // Handshakes: a fetch is accepted on a cycle with imem_req && imem_gnt, and its
    // single response arrives later as imem_rvalid with imem_rdata; an instruction
    // transfers downstream on a cycle with inst_valid && inst_ready, and
    // inst_valid/inst_out/inst_pc stay stable until then unless a redirect squashes them.
    modport master (
        input  BranchValid, BranchTaken, BranchTarget,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst_out, inst_pc,
        input  inst_ready,
        output misalign_err
    );

    modport slave (
        output BranchValid, BranchTaken, BranchTarget,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst_out, inst_pc,
        output inst_ready,
        input  misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Front-end PC sequencer: one outstanding instruction fetch at a time, a one-entry
// downstream holding stage, and taken-branch redirects that squash wrong-path fetches.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.master       bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_inflight;
    logic        r_discard;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst_out;
    logic [31:0] r_inst_pc;
    logic        r_misalign;

    logic        w_taken;
    logic        w_redirect;
    logic        w_misalign;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_redir;

    assign w_taken    = bus.BranchValid & bus.BranchTaken;
    assign w_redirect = w_taken & (bus.BranchTarget[1:0] == 2'b00);
    assign w_misalign = w_taken & (bus.BranchTarget[1:0] != 2'b00);
    assign w_pc_seq   = r_pc + 32'(PC_STEP);
    // PC to use for the next request when no grant is consumed this cycle.
    assign w_pc_redir = w_redirect ? bus.BranchTarget : r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pc_inflight <= 32'h0;
            r_discard     <= 1'b0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= 32'h0;
            r_inst_valid  <= 1'b0;
            r_inst_out    <= 32'h0;
            r_inst_pc     <= 32'h0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            case (r_state)
                S_IDLE: begin
                    r_pc        <= w_pc_redir;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_pc_redir;
                    r_state     <= S_REQ;
                end
                S_REQ: begin
                    if (bus.imem_gnt) begin
                        // A redirect in the grant cycle makes the accepted fetch stale.
                        r_pc_inflight <= r_pc;
                        r_pc          <= w_redirect ? bus.BranchTarget : w_pc_seq;
                        r_discard     <= w_redirect;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_WAIT;
                    end else if (w_redirect) begin
                        r_pc        <= bus.BranchTarget;
                        r_imem_addr <= bus.BranchTarget;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_discard || w_redirect) begin
                            r_discard   <= 1'b0;
                            r_pc        <= w_pc_redir;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= w_pc_redir;
                            r_state     <= S_REQ;
                        end else begin
                            r_inst_out   <= bus.imem_rdata;
                            r_inst_pc    <= r_pc_inflight;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_discard <= 1'b1;
                        r_pc      <= bus.BranchTarget;
                    end
                end
                S_HOLD: begin
                    // A redirect squashes the held word even if it is accepted this cycle.
                    if (w_redirect || bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_pc_redir;
                        r_imem_req   <= 1'b1;
                        r_imem_addr  <= w_pc_redir;
                        r_state      <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req     = r_imem_req;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.inst_out     = r_inst_out;
    assign bus.inst_pc      = r_inst_pc;
    assign bus.misalign_err = r_misalign;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed protocol scenarios followed by a randomized
// memory/branch/downstream environment checked against a transaction-level model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: next fetch address, one outstanding fetch, held word queue.
    logic [31:0] m_pc;
    logic        m_out;
    logic [31:0] m_out_pc;
    logic        m_stale;
    logic        m_mis;
    logic [31:0] exp_q[$];
    logic        exp_req;
    logic        r_gnt, r_rv, r_rdy, r_bv, r_bt, r_redir, r_mis;
    logic [31:0] r_tgt;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic branch(input logic v, input logic t, input logic [31:0] tgt);
        bus.BranchValid  = v;
        bus.BranchTaken  = t;
        bus.BranchTarget = tgt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {31'h0, bus.imem_req},     32'h0);
        chk({tag, "_addr"},  bus.imem_addr,             32'h0);
        chk({tag, "_valid"}, {31'h0, bus.inst_valid},   32'h0);
        chk({tag, "_out"},   bus.inst_out,              32'h0);
        chk({tag, "_pc"},    bus.inst_pc,               32'h0);
        chk({tag, "_mis"},   {31'h0, bus.misalign_err}, 32'h0);
    endtask

    // Entered with a request for address a on the bus; grants it, responds next
    // cycle, and returns with the fetched word presented downstream.
    task automatic fetch_ok(input logic [31:0] a);
        chk("fetch_req", {31'h0, bus.imem_req}, 32'h1);
        chk("fetch_addr", bus.imem_addr, a);
        bus.imem_gnt = 1'b1;
        step();
        chk("wait_req", {31'h0, bus.imem_req}, 32'h0);
        chk("wait_valid", {31'h0, bus.inst_valid}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(a);
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        chk("hold_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("hold_pc", bus.inst_pc, a);
        chk("hold_out", bus.inst_out, mem_f(a));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;
        branch(1'b0, 1'b0, 32'h0);
        step();
        step();
        chk_all_zero("reset");

        // Sequential fetch with everything tied ready.
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        bus.imem_gnt   = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            fetch_ok(32'(i * 4));
            step();
        end

        // Backpressure on 0x10.
        bus.inst_ready = 1'b0;
        fetch_ok(32'h10);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'h0, bus.inst_valid}, 32'h1);
            chk("bp_pc", bus.inst_pc, 32'h10);
            chk("bp_out", bus.inst_out, mem_f(32'h10));
            chk("bp_req", {31'h0, bus.imem_req}, 32'h0);
        end
        bus.inst_ready = 1'b1;
        step();
        chk("bp_release_valid", {31'h0, bus.inst_valid}, 32'h0);

        // Redirect while the 0x14 fetch is outstanding.
        chk("rw_addr", bus.imem_addr, 32'h14);
        step();
        chk("rw_req", {31'h0, bus.imem_req}, 32'h0);
        branch(1'b1, 1'b1, 32'h200);
        step();
        branch(1'b0, 1'b0, 32'h0);
        chk("rw_still_wait", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(32'h14);
        step();
        bus.imem_rvalid = 1'b0;
        chk("rw_stale_valid", {31'h0, bus.inst_valid}, 32'h0);
        fetch_ok(32'h200);
        step();

        // Redirect in the same cycle as the grant.
        chk("rg_addr", bus.imem_addr, 32'h204);
        branch(1'b1, 1'b1, 32'h300);
        step();
        branch(1'b0, 1'b0, 32'h0);
        chk("rg_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(32'h204);
        step();
        bus.imem_rvalid = 1'b0;
        chk("rg_stale_valid", {31'h0, bus.inst_valid}, 32'h0);
        fetch_ok(32'h300);
        step();

        // Redirect in the same cycle as the response.
        chk("rr_addr", bus.imem_addr, 32'h304);
        step();
        chk("rr_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(32'h304);
        branch(1'b1, 1'b1, 32'h400);
        step();
        bus.imem_rvalid = 1'b0;
        branch(1'b0, 1'b0, 32'h0);
        chk("rr_stale_valid", {31'h0, bus.inst_valid}, 32'h0);
        fetch_ok(32'h400);
        step();

        // Misaligned target, not-taken branch, and unqualified taken flag.
        bus.imem_gnt = 1'b0;
        chk("mis_addr0", bus.imem_addr, 32'h404);
        branch(1'b1, 1'b1, 32'h202);
        step();
        branch(1'b1, 1'b0, 32'h800);
        chk("mis_pulse", {31'h0, bus.misalign_err}, 32'h1);
        chk("mis_addr1", bus.imem_addr, 32'h404);
        step();
        branch(1'b0, 1'b1, 32'h900);
        chk("mis_clear", {31'h0, bus.misalign_err}, 32'h0);
        chk("nt_addr", bus.imem_addr, 32'h404);
        step();
        branch(1'b0, 1'b0, 32'h0);
        chk("nv_addr", bus.imem_addr, 32'h404);
        fetch_ok(32'h404);
        step();

        // PC wrap at the top of the address space.
        bus.imem_gnt = 1'b0;
        branch(1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        branch(1'b0, 1'b0, 32'h0);
        fetch_ok(32'hFFFF_FFFC);
        step();
        chk("wrap_req", {31'h0, bus.imem_req}, 32'h1);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Asynchronous reset with a fetch outstanding, then a late response.
        step();
        chk("ar_wait_req", {31'h0, bus.imem_req}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ar_req", {31'h0, bus.imem_req}, 32'h1);
        chk("ar_addr", bus.imem_addr, 32'h0);
        chk("ar_valid", {31'h0, bus.inst_valid}, 32'h0);
        bus.imem_gnt = 1'b0;
        step();
        bus.imem_rvalid = 1'b0;
        chk("late_rvalid_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("late_rvalid_req", {31'h0, bus.imem_req}, 32'h1);

        // Randomized environment against the transaction-level model.
        m_pc    = 32'h0;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_mis   = 1'b0;
        m_out_pc = 32'h0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            exp_req = !m_out && (exp_q.size() == 0);
            chk("rnd_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
            if (exp_req) chk("rnd_addr", bus.imem_addr, m_pc);
            chk("rnd_valid", {31'h0, bus.inst_valid}, {31'h0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("rnd_pc", bus.inst_pc, exp_q[0]);
                chk("rnd_out", bus.inst_out, mem_f(exp_q[0]));
            end
            chk("rnd_mis", {31'h0, bus.misalign_err}, {31'h0, m_mis});

            r_gnt = ($urandom_range(0, 9) < 6);
            r_rv  = m_out ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            r_rdy = 1'($urandom_range(0, 1));
            r_bv  = ($urandom_range(0, 9) < 2);
            r_bt  = ($urandom_range(0, 9) < 7);
            r_tgt = 32'($urandom_range(0, 16383)) << 2;
            if ($urandom_range(0, 4) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
            bus.imem_gnt    = r_gnt;
            bus.imem_rvalid = r_rv;
            bus.imem_rdata  = m_out ? mem_f(m_out_pc) : $urandom;
            bus.inst_ready  = r_rdy;
            branch(r_bv, r_bt, r_tgt);

            r_redir = r_bv && r_bt && (r_tgt[1:0] == 2'b00);
            r_mis   = r_bv && r_bt && (r_tgt[1:0] != 2'b00);
            m_mis   = r_mis;
            if (exp_q.size() != 0 && (r_rdy || r_redir)) void'(exp_q.pop_front());
            if (m_out && r_rv) begin
                m_out = 1'b0;
                if (!m_stale && !r_redir) exp_q.push_back(m_out_pc);
            end else if (m_out && r_redir) begin
                m_stale = 1'b1;
            end
            if (exp_req && r_gnt) begin
                m_out    = 1'b1;
                m_out_pc = m_pc;
                m_stale  = r_redir;
                m_pc     = r_redir ? r_tgt : m_pc + 32'd4;
            end else if (r_redir) begin
                m_pc = r_tgt;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
